// File: rtl/mmio_peripheral_if.sv
// mmio_peripheral_if: MEM-stage load/store bus between the pipeline (master) and the peripheral (slave).
interface mmio_peripheral_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    modport master (output MemRead, MemWrite, Address, WriteData, input ReadData);
    modport slave (input MemRead, MemWrite, Address, WriteData, output ReadData);
endinterface

// File: rtl/mmio_peripheral.sv
// mmio_peripheral: 6-word MMIO window with a reloading timer and IRQ, LED/7-seg registers and a free-running tick.
module mmio_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic                clk,
    input  logic                reset,
    mmio_peripheral_if.slave    bus,
    output logic                IRQ,
    output logic [15:0]         led,
    output logic [3:0]          AN,
    output logic [7:0]          BCD
);
    logic [31:0] th_q, th_d, tl_q, tl_d, systick_q;
    logic [2:0]  tcon_q, tcon_d;
    logic [15:0] led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [29:0] off;
    logic        ovf, set_irq, unused_addr;

    // Addresses below the base wrap to a huge offset and decode as unmapped.
    assign off         = bus.Address[31:2] - BASE_ADDR[31:2];
    assign unused_addr = &bus.Address[1:0];
    assign ovf         = tcon_q[0] && tl_q == 32'hFFFFFFFF;
    assign set_irq     = ovf && tcon_q[1];

    always_comb begin
        bus.ReadData = 32'h0;
        if (bus.MemRead)
            case (off)
                30'd0:   bus.ReadData = th_q;
                30'd1:   bus.ReadData = tl_q;
                30'd2:   bus.ReadData = {29'h0, tcon_q};
                30'd3:   bus.ReadData = {16'h0, led_q};
                30'd4:   bus.ReadData = {20'h0, digi_q};
                30'd5:   bus.ReadData = systick_q;
                default: bus.ReadData = 32'h0;
            endcase
    end

    always_comb begin
        th_d   = bus.MemWrite && off == 30'd0 ? bus.WriteData : th_q;
        tl_d   = bus.MemWrite && off == 30'd1 ? bus.WriteData :
                 !tcon_q[0] ? tl_q : ovf ? th_q : tl_q + 32'd1;
        tcon_d = bus.MemWrite && off == 30'd2 ? {bus.WriteData[2] | set_irq, bus.WriteData[1:0]} :
                 {tcon_q[2] | set_irq, tcon_q[1:0]};
        led_d  = bus.MemWrite && off == 30'd3 ? bus.WriteData[15:0] : led_q;
        digi_d = bus.MemWrite && off == 30'd4 ? bus.WriteData[11:0] : digi_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= 32'h0;
            tl_q      <= 32'h0;
            tcon_q    <= 3'h0;
            led_q     <= 16'h0;
            digi_q    <= 12'h0;
            systick_q <= 32'h0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_q + 32'd1;
        end
    end

    assign IRQ = tcon_q[1] & tcon_q[2];
    assign led = led_q;
    assign AN  = digi_q[11:8];
    assign BCD = digi_q[7:0];
endmodule

// File: tb/tb_mmio_peripheral.sv
// tb_mmio_peripheral: directed-vector bench for mmio_peripheral with hand-computed expectations.
module tb_mmio_peripheral;
    localparam logic [31:0] B = 32'h40000000;
    logic        clk = 1'b0, reset = 1'b1, IRQ;
    logic [15:0] led;
    logic [3:0]  AN;
    logic [7:0]  BCD;
    int          n_vec = 0, n_err = 0;
    logic [31:0] t0, t1;

    mmio_peripheral_if bus ();
    mmio_peripheral dut (.clk(clk), .reset(reset), .bus(bus), .IRQ(IRQ), .led(led), .AN(AN), .BCD(BCD));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite = 1'b1;
        bus.Address = a;
        bus.WriteData = d;
        @(negedge clk);
        bus.MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.MemRead = 1'b1;
        bus.Address = a;
        #1 d = bus.ReadData;
        bus.MemRead = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Address = 32'h0;
        bus.WriteData = 32'h0;
        #2;
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_digi", {20'h0, AN, BCD}, 32'h0);
        step();
        reset = 1'b0;
        // Register read/write and decode
        wr(B + 32'h0C, 32'hDEADBEEF);
        check("led_out", {16'h0, led}, 32'h0000BEEF);
        chk_rd("led_rd", B + 32'h0C, 32'h0000BEEF);
        wr(B + 32'h10, 32'h0000FFFF);
        check("an_bcd", {20'h0, AN, BCD}, 32'h00000FFF);
        chk_rd("digi_rd", B + 32'h10, 32'h00000FFF);
        wr(B + 32'h18, 32'h12345678);
        wr(B - 32'h4, 32'h87654321);
        chk_rd("unmapped_rd", B + 32'h18, 32'h0);
        chk_rd("th_untouched", B, 32'h0);
        bus.Address = B + 32'h0C;
        #1 check("no_memread", bus.ReadData, 32'h0);
        bus.MemRead = 1'b1;
        bus.MemWrite = 1'b1;
        bus.WriteData = 32'h00001111;
        #1 check("rw_old", bus.ReadData, 32'h0000BEEF);
        @(negedge clk);
        bus.MemWrite = 1'b0;
        #1 check("rw_new", bus.ReadData, 32'h00001111);
        bus.MemRead = 1'b0;
        // Timer reload and IRQ
        step();
        wr(B, 32'hFFFFFFFC);
        wr(B + 32'h4, 32'hFFFFFFFC);
        wr(B + 32'h8, 32'h3);
        chk_rd("tl_start", B + 32'h4, 32'hFFFFFFFC);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_rd($sformatf("tl_cnt%0d", i), B + 32'h4, 32'hFFFFFFFD + i);
            check($sformatf("irq_lo%0d", i), {31'h0, IRQ}, 32'h0);
        end
        step();
        chk_rd("tl_reload", B + 32'h4, 32'hFFFFFFFC);
        chk_rd("tcon_7", B + 32'h8, 32'h7);
        check("irq_hi", {31'h0, IRQ}, 32'h1);
        step(); step(); step();
        chk_rd("tl_ff", B + 32'h4, 32'hFFFFFFFF);
        // Software clear in the overflow cycle loses to the hardware set
        wr(B + 32'h8, 32'h3);
        chk_rd("race_tcon", B + 32'h8, 32'h7);
        chk_rd("race_tl", B + 32'h4, 32'hFFFFFFFC);
        check("race_irq", {31'h0, IRQ}, 32'h1);
        wr(B + 32'h8, 32'h3);
        chk_rd("clr_tcon", B + 32'h8, 32'h3);
        check("clr_irq", {31'h0, IRQ}, 32'h0);
        // TL write beats increment
        wr(B + 32'h4, 32'h100);
        chk_rd("tl_wr", B + 32'h4, 32'h100);
        step();
        chk_rd("tl_inc", B + 32'h4, 32'h101);
        // TH write during reload: TL takes old TH
        wr(B + 32'h4, 32'hFFFFFFFF);
        wr(B, 32'h10);
        chk_rd("th_new", B, 32'h10);
        chk_rd("tl_old_th", B + 32'h4, 32'hFFFFFFFC);
        wr(B + 32'h8, 32'h0);
        chk_rd("tl_hold_a", B + 32'h4, 32'hFFFFFFFD);
        step(); step();
        chk_rd("tl_hold_b", B + 32'h4, 32'hFFFFFFFD);
        // SYSTICK read-only and free-running
        rd(B + 32'h14, t0);
        wr(B + 32'h14, 32'h55);
        rd(B + 32'h14, t1);
        check("systick_ro", t1 - t0, 32'h1);
        rd(B + 32'h14, t0);
        repeat (5) step();
        rd(B + 32'h14, t1);
        check("systick_n", t1 - t0, 32'h5);
        // Asynchronous reset mid-operation
        wr(B + 32'h4, 32'h1234);
        wr(B + 32'h0C, 32'hFFFF);
        wr(B + 32'h8, 32'h6);
        check("pre_rst_irq", {31'h0, IRQ}, 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_led", {16'h0, led}, 32'h0);
        check("mid_rst_irq", {31'h0, IRQ}, 32'h0);
        chk_rd("mid_rst_tl", B + 32'h4, 32'h0);
        step();
        reset = 1'b0;
        chk_rd("tick_rel", B + 32'h14, 32'h0);
        step();
        chk_rd("tick_first", B + 32'h14, 32'h1);
        chk_rd("tl_disabled", B + 32'h4, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
